dmem_bus_bridge: RTL and testbench



---
 rtl/dmem_bus_bridge.sv | 196 +++++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//
// Connects the core's single-cycle data-memory port to a multi-cycle
// request/acknowledge system bus. Each load or store becomes one bus
// transaction. Store data is replicated onto the addressed byte lanes. Load
// data comes back right-justified, so the core's sign/zero extension needs no
// change. The core is held through hlt_o until the transaction completes.
// Misaligned or illegal accesses never reach the bus and set a sticky flag.
// Bus errors and timeouts set a separate sticky flag.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   dmem_addr_i[31:0]     byte address from the core
//   dmem_data_i[31:0]     right-justified store data
//   dmem_access_width_i   000 B, 001 H, 010 W, 100 BU, 101 HU
//   dmem_we_i, dmem_re_i  store / load strobes (a store wins if both are set)
//   ext_hlt_i             external halt request, ORed into hlt_o
//   dmem_data_o[31:0]     load data, valid only in the commit (DONE) cycle
//   hlt_o                 combinational core halt
//   bus_req_o/we/addr/sel/wdata   registered bus request signals
//   bus_rdata_i, bus_ack_i, bus_err_i   bus response (err beats ack)
//   misaligned_o, bus_fault_o   sticky flags, cleared only by reset
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_data_i,
   input  logic [2:0]  dmem_access_width_i,
   input  logic        dmem_we_i,
   input  logic        dmem_re_i,
   input  logic        ext_hlt_i,
   output logic [31:0] dmem_data_o,
   output logic        hlt_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [29:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   output logic        misaligned_o,
   output logic        bus_fault_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg;
   logic        bus_req_reg;
   logic        bus_we_reg;
   logic [29:0] bus_addr_reg;
   logic [3:0]  bus_sel_reg;
   logic [31:0] bus_wdata_reg;
   logic [1:0]  offset_reg;
   logic [31:0] rdata_reg;
   logic [31:0] cnt_reg;
   logic        misaligned_reg;
   logic        fault_reg;

   logic        access_valid;
   logic        width_legal;
   logic        bad_align;
   logic        start_access;
   logic        reject_access;
   logic        timeout_hit;
   logic [3:0]  sel_next;
   logic [31:0] wdata_next;
   logic [31:0] rdata_shifted;

   // An access is only considered in IDLE and while no external halt is
   // pending; a strobe still high during DONE belongs to the instruction that
   // is committing and must not start a second transaction.
   assign access_valid = (state_reg == IDLE) && (dmem_we_i || dmem_re_i) && !ext_hlt_i;

   always_comb begin
      width_legal = 1'b0;
      bad_align   = 1'b0;
      sel_next    = 4'b0000;
      wdata_next  = dmem_data_i;
      case (dmem_access_width_i)
         3'b000, 3'b100: begin
            width_legal = 1'b1;
            sel_next    = 4'b0001 << dmem_addr_i[1:0];
            wdata_next  = {4{dmem_data_i[7:0]}};
         end
         3'b001, 3'b101: begin
            width_legal = 1'b1;
            bad_align   = dmem_addr_i[0];
            sel_next    = 4'b0011 << dmem_addr_i[1:0];
            wdata_next  = {2{dmem_data_i[15:0]}};
         end
         3'b010: begin
            width_legal = 1'b1;
            bad_align   = (dmem_addr_i[1:0] != 2'b00);
            sel_next    = 4'b1111;
            wdata_next  = dmem_data_i;
         end
         default: begin
            width_legal = 1'b0;
         end
      endcase
   end

   assign start_access  = access_valid && width_legal && !bad_align;
   assign reject_access = access_valid && (!width_legal || bad_align);

   // The counter holds the number of completed BUS cycles, so reaching T-1
   // during a BUS cycle means this is the T-th cycle without a response.
   // An ack arriving in that same cycle still completes the access normally.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TIMEOUT_CYCLES - 32'd1);

   // Upper lanes are passed through unmasked; the core's load extension
   // discards them.
   assign rdata_shifted = bus_rdata_i >> {offset_reg, 3'b000};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         bus_req_reg    <= 1'b0;
         bus_we_reg     <= 1'b0;
         bus_addr_reg   <= '0;
         bus_sel_reg    <= '0;
         bus_wdata_reg  <= '0;
         offset_reg     <= '0;
         rdata_reg      <= '0;
         cnt_reg        <= '0;
         misaligned_reg <= 1'b0;
         fault_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_access) begin
                  state_reg     <= BUS;
                  bus_req_reg   <= 1'b1;
                  bus_we_reg    <= dmem_we_i;
                  bus_addr_reg  <= dmem_addr_i[31:2];
                  bus_sel_reg   <= sel_next;
                  bus_wdata_reg <= wdata_next;
                  offset_reg    <= dmem_addr_i[1:0];
                  cnt_reg       <= '0;
               end
               if (reject_access) begin
                  misaligned_reg <= 1'b1;
               end
            end
            BUS: begin
               cnt_reg <= cnt_reg + 32'd1;
               if (bus_err_i) begin
                  fault_reg   <= 1'b1;
                  rdata_reg   <= '0;
                  bus_req_reg <= 1'b0;
                  state_reg   <= DONE;
               end else if (bus_ack_i) begin
                  rdata_reg   <= rdata_shifted;
                  bus_req_reg <= 1'b0;
                  state_reg   <= DONE;
               end else if (timeout_hit) begin
                  fault_reg   <= 1'b1;
                  rdata_reg   <= '0;
                  bus_req_reg <= 1'b0;
                  state_reg   <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg   <= IDLE;
               bus_req_reg <= 1'b0;
            end
         endcase
      end
   end

   // Halt is raised in the same cycle the access is seen so the core does not
   // advance past the load/store. It is released in DONE so the core commits.
   assign hlt_o = !rst_i && (ext_hlt_i || start_access || (state_reg == BUS));

   assign dmem_data_o  = (state_reg == DONE) ? rdata_reg : 32'd0;
   assign bus_req_o    = bus_req_reg;
   assign bus_we_o     = bus_we_reg;
   assign bus_addr_o   = bus_addr_reg;
   assign bus_sel_o    = bus_sel_reg;
   assign bus_wdata_o  = bus_wdata_reg;
   assign misaligned_o = misaligned_reg;
   assign bus_fault_o  = fault_reg;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
//
// Self-checking bench for dmem_bus_bridge. A driver issues core accesses
// (directed cases, then random ones). For every access that should reach the
// bus, it pushes the expected bus request and expected result into a
// scoreboard queue. It also pushes the slave's scripted response into a
// second queue. A monitor pops the scoreboard when a request appears and
// checks the request and the commit cycle. A slave model answers with the
// scripted latency and response kind.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

   localparam int T = 6;   // bus timeout used for this bench

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] dmem_addr_i = '0;
   logic [31:0] dmem_data_i = '0;
   logic [2:0]  dmem_access_width_i = '0;
   logic        dmem_we_i = 1'b0;
   logic        dmem_re_i = 1'b0;
   logic        ext_hlt_i = 1'b0;
   logic [31:0] dmem_data_o;
   logic        hlt_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [29:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_ack_i = 1'b0;
   logic        bus_err_i = 1'b0;
   logic        misaligned_o;
   logic        bus_fault_o;

   always #5 clk_i = ~clk_i;

   dmem_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .dmem_addr_i         (dmem_addr_i),
      .dmem_data_i         (dmem_data_i),
      .dmem_access_width_i (dmem_access_width_i),
      .dmem_we_i           (dmem_we_i),
      .dmem_re_i           (dmem_re_i),
      .ext_hlt_i           (ext_hlt_i),
      .dmem_data_o         (dmem_data_o),
      .hlt_o               (hlt_o),
      .bus_req_o           (bus_req_o),
      .bus_we_o            (bus_we_o),
      .bus_addr_o          (bus_addr_o),
      .bus_sel_o           (bus_sel_o),
      .bus_wdata_o         (bus_wdata_o),
      .bus_rdata_i         (bus_rdata_i),
      .bus_ack_i           (bus_ack_i),
      .bus_err_i           (bus_err_i),
      .misaligned_o        (misaligned_o),
      .bus_fault_o         (bus_fault_o)
   );

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        chk_data;
      logic [31:0] data;
      int          reqcyc;
      logic        fault;
   } exp_t;

   // kind: 0 ack, 1 err, 2 err together with ack; lat 99 = never answer
   typedef struct {
      int          lat;
      int          kind;
      logic [31:0] rdata;
   } rsp_t;

   exp_t exp_q[$];
   rsp_t rsp_q[$];

   int   n_checks = 0;
   int   n_fail   = 0;
   logic fault_model = 1'b0;
   logic mis_model   = 1'b0;
   logic slave_en    = 1'b1;
   logic force_ack   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // ---------------- slave model ----------------
   initial begin
      int   k;
      logic active;
      rsp_t cur;
      active    = 1'b0;
      k         = 0;
      cur.lat   = 99;
      cur.kind  = 0;
      cur.rdata = '0;
      forever begin
         @(posedge clk_i);
         #2;
         bus_rdata_i = $urandom;
         bus_ack_i   = 1'b0;
         bus_err_i   = 1'b0;
         if (!slave_en) begin
            bus_ack_i = force_ack;
            active    = 1'b0;
         end else if (bus_req_o) begin
            if (!active) begin
               active = 1'b1;
               k      = 0;
               if (rsp_q.size() > 0) cur = rsp_q.pop_front();
               else cur.lat = 99;
            end else begin
               k++;
            end
            if (k == cur.lat) begin
               bus_rdata_i = cur.rdata;
               bus_ack_i   = (cur.kind != 1);
               bus_err_i   = (cur.kind != 0);
            end
         end else begin
            active = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic prev;
      int   rc;
      exp_t cur;
      prev = 1'b0;
      rc   = 0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            prev = 1'b0;
         end else begin
            if (bus_req_o && !prev) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_req", 32'(bus_req_o), 32'd0);
                  cur.we = bus_we_o; cur.addr = bus_addr_o; cur.sel = bus_sel_o;
                  cur.wdata = bus_wdata_o; cur.chk_data = 1'b0; cur.data = '0;
                  cur.reqcyc = 0; cur.fault = bus_fault_o;
               end else begin
                  cur = exp_q.pop_front();
                  chk("bus_we", 32'(bus_we_o), 32'(cur.we));
                  chk("bus_addr", 32'(bus_addr_o), 32'(cur.addr));
                  chk("bus_sel", 32'(bus_sel_o), 32'(cur.sel));
                  if (cur.we) chk("bus_wdata", bus_wdata_o, cur.wdata);
               end
               $display("bus req: we=%0d addr=%h sel=%b wdata=%h", bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
               rc = 1;
            end else if (bus_req_o && prev) begin
               rc++;
               chk("stable_addr", 32'(bus_addr_o), 32'(cur.addr));
               chk("stable_sel", 32'(bus_sel_o), 32'(cur.sel));
            end else if (!bus_req_o && prev) begin
               chk("req_cycles", 32'(rc), 32'(cur.reqcyc));
               chk("done_hlt", 32'(hlt_o), 32'd0);
               chk("bus_fault", 32'(bus_fault_o), 32'(cur.fault));
               if (cur.chk_data) chk("load_data", dmem_data_o, cur.data);
               $display("commit: req_cycles=%0d data=%h fault=%0d", rc, dmem_data_o, bus_fault_o);
            end
            if (bus_req_o) chk("data_zero_in_bus", dmem_data_o, 32'd0);
            prev = bus_req_o;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic access(input logic we, input logic re, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d, input int ext,
                         input int lat, input int kind, input logic [31:0] rd,
                         input int gap);
      int   bytes;
      logic legal;
      logic mis;
      logic thisfault;
      int   selv;
      int   hexp;
      int   n;
      logic done;
      exp_t e;
      rsp_t r;
      legal = (w == 3'b000) || (w == 3'b001) || (w == 3'b010) || (w == 3'b100) || (w == 3'b101);
      bytes = (w[1:0] == 2'd0) ? 1 : ((w[1:0] == 2'd1) ? 2 : 4);
      mis   = legal ? ((a % bytes) != 0) : 1'b1;
      hexp  = 0;
      if (!mis) begin
         selv = ((1 << bytes) - 1) << (a % 4);
         if (bytes == 1)      e.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
         else if (bytes == 2) e.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
         else                 e.wdata = d;
         thisfault   = (lat >= T) || (kind != 0);
         fault_model = fault_model | thisfault;
         e.we        = we;
         e.addr      = a[31:2];
         e.sel       = selv[3:0];
         e.chk_data  = !we;
         e.data      = thisfault ? 32'd0 : (rd >> (8 * (a % 4)));
         e.reqcyc    = (lat >= T) ? T : lat + 1;
         e.fault     = fault_model;
         r.lat       = lat;
         r.kind      = kind;
         r.rdata     = rd;
         exp_q.push_back(e);
         rsp_q.push_back(r);
         hexp = e.reqcyc + 1;
      end else begin
         mis_model = 1'b1;
      end
      $display("access: we=%0d re=%0d w=%b addr=%h data=%h ext=%0d lat=%0d kind=%0d mis=%0d",
               we, re, w, a, d, ext, lat, kind, mis);
      @(posedge clk_i);
      #1;
      dmem_we_i = we; dmem_re_i = re; dmem_access_width_i = w;
      dmem_addr_i = a; dmem_data_i = d;
      ext_hlt_i = (ext > 0);
      for (int i = 0; i < ext; i++) begin
         @(negedge clk_i);
         chk("ext_blocks_req", 32'(bus_req_o), 32'd0);
         chk("ext_hlt", 32'(hlt_o), 32'd1);
         @(posedge clk_i);
         #1;
      end
      ext_hlt_i = 1'b0;
      n    = 0;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk_i);
         if (i == 1 && ext > 0 && !mis) chk("req_after_ext", 32'(bus_req_o), 32'd1);
         if (!hlt_o) done = 1'b1;
         else n++;
      end
      if (!done) chk("commit_timeout", 32'(hlt_o), 32'd0);
      chk("halt_cycles", 32'(n), 32'(hexp));
      if (mis) chk("mis_data_zero", dmem_data_o, 32'd0);
      if (mis || gap > 0) begin
         @(posedge clk_i);
         #1;
         dmem_we_i = 1'b0; dmem_re_i = 1'b0;
         dmem_addr_i = $urandom; dmem_data_i = $urandom;
         @(negedge clk_i);
         chk("misaligned_flag", 32'(misaligned_o), 32'(mis_model));
         if (mis) chk("mis_no_req", 32'(bus_req_o), 32'd0);
      end
   endtask

   initial begin
      logic [2:0] legal_w [5];
      logic [2:0] w;
      logic [31:0] a;
      logic we;
      logic re;
      int r;
      exp_t e;
      legal_w = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      // reset, with a strobe and external halt asserted to show hlt_o is forced low
      rst_i = 1'b1; ext_hlt_i = 1'b1; dmem_re_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_hlt", 32'(hlt_o), 32'd0);
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_we", 32'(bus_we_o), 32'd0);
      chk("rst_sel", 32'(bus_sel_o), 32'd0);
      chk("rst_addr", 32'(bus_addr_o), 32'd0);
      chk("rst_wdata", bus_wdata_o, 32'd0);
      chk("rst_mis", 32'(misaligned_o), 32'd0);
      chk("rst_fault", 32'(bus_fault_o), 32'd0);
      chk("rst_data", dmem_data_o, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0; ext_hlt_i = 1'b0; dmem_re_i = 1'b0;

      // directed cases
      access(1'b0, 1'b1, 3'b100, 32'h0000_1003, 32'h0, 0, 0, 0, 32'hAABB_CCDD, 1);
      access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h1234_5678, 0, 3, 0, 32'h0, 1);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0001, 32'h0, 0, 0, 0, 32'h0, 1);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h0, 0, 0, 0, 32'hCAFE_F00D, 1);
      access(1'b1, 1'b1, 3'b000, 32'h0000_0042, 32'h0000_00A5, 0, 1, 0, 32'h0, 0);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 0, 0, 0, 32'h1111_2222, 0);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h0, 5, 1, 0, 32'h3333_4444, 1);
      access(1'b0, 1'b1, 3'b011, 32'h0000_0300, 32'h0, 0, 0, 0, 32'h0, 1);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 0, 99, 0, 32'h0, 1);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0, 0, 1, 2, 32'h5555_6666, 1);

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         we = 1'($urandom_range(0, 1));
         re = we ? 1'($urandom_range(0, 1)) : 1'b1;
         r  = $urandom_range(0, 19);
         if (r < 18) w = legal_w[r % 5];
         else w = (r == 18) ? 3'b011 : 3'b111;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         access(we, re, w, a, $urandom,
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, T - 2),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0,
                $urandom, $urandom_range(0, 1));
      end

      // reset during a pending store; a late ack must be ignored
      slave_en = 1'b0;
      e.we = 1'b1; e.addr = 30'h0000_0C00; e.sel = 4'b1111; e.wdata = 32'hDEAD_BEEF;
      e.chk_data = 1'b0; e.data = '0; e.reqcyc = 0; e.fault = 1'b0;
      exp_q.push_back(e);
      $display("access: SW addr=00003000 data=deadbeef with reset in cycle 2");
      @(posedge clk_i);
      #1;
      dmem_we_i = 1'b1; dmem_re_i = 1'b0; dmem_access_width_i = 3'b010;
      dmem_addr_i = 32'h0000_3000; dmem_data_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      chk("sw_hlt", 32'(hlt_o), 32'd1);
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("sw_req", 32'(bus_req_o), 32'd1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1; dmem_we_i = 1'b0;
      @(negedge clk_i);
      chk("hlt_forced_in_rst", 32'(hlt_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0; force_ack = 1'b1;
      @(negedge clk_i);
      chk("rst_req_drop", 32'(bus_req_o), 32'd0);
      @(posedge clk_i);
      #1;
      force_ack = 1'b0;
      @(negedge clk_i);
      chk("late_ack_req", 32'(bus_req_o), 32'd0);
      chk("late_ack_hlt", 32'(hlt_o), 32'd0);
      chk("late_ack_mis", 32'(misaligned_o), 32'd0);
      chk("late_ack_fault", 32'(bus_fault_o), 32'd0);
      chk("late_ack_data", dmem_data_o, 32'd0);
      fault_model = 1'b0;
      mis_model   = 1'b0;
      slave_en    = 1'b1;

      // recovery after reset
      access(1'b0, 1'b1, 3'b101, 32'h0000_0406, 32'h0, 0, 2, 0, 32'h89AB_CDEF, 0);
      access(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h0, 0, 0, 0, 32'h0BAD_F00D, 1);

      repeat (4) @(negedge clk_i);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("final_mis", 32'(misaligned_o), 32'(mis_model));
      chk("final_fault", 32'(bus_fault_o), 32'(fault_model));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
